// File: rtl/custom_clock.sv
// Programmable clock divider: clock_signal toggles every (cycle_delay + 1) clk
// rising edges, giving a 50% duty square wave with period 2*(cycle_delay + 1).
module custom_clock #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] cycle_delay,
    output logic             clock_signal
);

    logic [WIDTH-1:0] counter_q, counter_d;
    logic             clk_q, clk_d;

    // Compare with >= so a delay lowered below the running count toggles on the
    // next edge. Because of that, the counter only increments while it is below
    // cycle_delay, so it can never wrap, even for an all-ones delay.
    always_comb begin
        counter_d = counter_q + 1'b1;
        clk_d     = clk_q;
        if (counter_q >= cycle_delay) begin
            counter_d = '0;
            clk_d     = ~clk_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            counter_q <= '0;
            clk_q     <= 1'b0;
        end else begin
            counter_q <= counter_d;
            clk_q     <= clk_d;
        end
    end

    assign clock_signal = clk_q;

endmodule

// File: tb/tb_custom_clock.sv
// Self-checking bench for custom_clock: directed scenarios plus randomized
// delay/reset traffic, checked against a per-edge reference model.
module tb_custom_clock;

    logic        clk;
    logic        rst_n;
    logic [31:0] cycle_delay;
    logic        clock_signal;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state: output level and edges elapsed in the current half period
    bit     m_lvl = 1'b0;
    longint m_elapsed = 0;
    longint edge_n = 0;
    bit     prev_lvl = 1'b0;
    longint tog_q[$];

    custom_clock #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cycle_delay  (cycle_delay),
        .clock_signal (clock_signal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    // One clk edge: predict the outcome from the inputs present at the edge,
    // then compare the DUT and log any observed toggle of clock_signal.
    task automatic tick();
        longint half;
        half = longint'(cycle_delay) + 1;
        if (!rst_n) begin
            m_lvl     = 1'b0;
            m_elapsed = 0;
        end else if (m_elapsed + 1 >= half) begin
            // this edge completes the half period (or the delay shrank under us)
            m_lvl     = ~m_lvl;
            m_elapsed = 0;
        end else begin
            m_elapsed = m_elapsed + 1;
        end
        edge_n++;
        @(posedge clk);
        #1;
        chk("clock_signal", longint'(clock_signal), longint'(m_lvl));
        chk("counter", longint'(dut.counter_q), m_elapsed);
        if (clock_signal !== prev_lvl) tog_q.push_back(edge_n);
        prev_lvl = clock_signal;
    endtask

    task automatic restart();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        edge_n = 0;
        tog_q.delete();
    endtask

    initial begin
        longint sw_edge;
        int     guard;

        // Reset held for 5 clks
        rst_n = 1'b0;
        cycle_delay = 32'd3;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_level", longint'(clock_signal), 0);
        end

        // Basic division by 8
        rst_n = 1'b1;
        edge_n = 0;
        tog_q.delete();
        for (int i = 0; i < 16; i++) tick();
        chk("basic_tog_cnt", tog_q.size(), 4);
        if (tog_q.size() >= 4) begin
            chk("basic_rise", tog_q[0], 4);
            chk("basic_fall", tog_q[1], 8);
            chk("basic_rise2", tog_q[2], 12);
            chk("basic_fall2", tog_q[3], 16);
        end

        // Minimum delay: toggle every edge
        cycle_delay = 32'd0;
        restart();
        for (int i = 0; i < 6; i++) tick();
        chk("min_tog_cnt", tog_q.size(), 6);
        for (int i = 0; i < tog_q.size(); i++) chk("min_tog_edge", tog_q[i], i + 1);

        // Dynamic shrink from 10 to 2 while counter = 7
        cycle_delay = 32'd10;
        restart();
        guard = 0;
        while (dut.counter_q !== 32'd7 && guard < 50) begin
            tick();
            guard++;
        end
        chk("dyn_reached7", longint'(dut.counter_q), 7);
        sw_edge = edge_n;
        tog_q.delete();
        cycle_delay = 32'd2;
        for (int i = 0; i < 13; i++) tick();
        chk("dyn_tog_cnt", tog_q.size(), 5);
        if (tog_q.size() >= 5) begin
            chk("dyn_first", tog_q[0], sw_edge + 1);
            for (int i = 1; i < 5; i++) chk("dyn_half", tog_q[i] - tog_q[i-1], 3);
        end

        // Mid-operation reset with clock_signal = 1, counter = 3
        cycle_delay = 32'd5;
        restart();
        guard = 0;
        while (!(clock_signal === 1'b1 && dut.counter_q === 32'd3) && guard < 100) begin
            tick();
            guard++;
        end
        chk("mid_hi", longint'(clock_signal), 1);
        chk("mid_cnt3", longint'(dut.counter_q), 3);
        restart();
        chk("mid_rst_lvl", longint'(clock_signal), 0);
        for (int i = 0; i < 8; i++) tick();
        chk("mid_tog_cnt", tog_q.size(), 1);
        if (tog_q.size() >= 1) chk("mid_rise", tog_q[0], 6);

        // Large delay, 10 full periods, no drift
        cycle_delay = 32'd1000;
        restart();
        for (int i = 0; i < 20 * 1001; i++) tick();
        chk("big_tog_cnt", tog_q.size(), 20);
        if (tog_q.size() >= 20) begin
            chk("big_first", tog_q[0], 1001);
            for (int i = 1; i < 20; i++) chk("big_half", tog_q[i] - tog_q[i-1], 1001);
        end

        // Randomized delay changes and occasional resets
        cycle_delay = 32'd4;
        restart();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) cycle_delay = $urandom_range(0, 7);
            rst_n = ($urandom_range(0, 99) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
